// File: rtl/dma_psdpram_fwd.sv
// Segmented simple dual-port RAM with same-cycle write-to-read forwarding and credit-managed
// per-segment response FIFOs. Define DMA_PSDPRAM_PARITY_EN for per-byte even parity storage.

module dma_psdpram_fwd #(
  parameter int SIZE           = 4096,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
  parameter int SEG_ADDR_WIDTH = $clog2(SIZE / (SEG_COUNT * SEG_BE_WIDTH)),
  parameter int PIPELINE       = 2,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data,
  input  logic [SEG_COUNT-1:0]                wr_cmd_valid,
  output logic [SEG_COUNT-1:0]                wr_cmd_ready,
  output logic [SEG_COUNT-1:0]                wr_done,
`ifdef DMA_PSDPRAM_PARITY_EN
  input  logic [SEG_COUNT-1:0]                wr_cmd_par_inv,
`endif
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data,
  output logic [SEG_COUNT-1:0]                rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                rd_resp_ready,
  output logic [SEG_COUNT-1:0]                rd_resp_err
);

  localparam int INT_ADDR_WIDTH = $clog2(SIZE / (SEG_COUNT * SEG_BE_WIDTH));
  localparam int WORDS          = 2 ** INT_ADDR_WIDTH;
  localparam int PTR_W          = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int CNT_W          = $clog2(OUT_FIFO_DEPTH + 1);

  if (SEG_ADDR_WIDTH < INT_ADDR_WIDTH) begin : g_chk_addr
    $error("SEG_ADDR_WIDTH smaller than required internal address width");
  end
  if (PIPELINE < 1) begin : g_chk_pipe
    $error("PIPELINE must be at least 1");
  end
  if (SEG_DATA_WIDTH % 8 != 0) begin : g_chk_width
    $error("SEG_DATA_WIDTH must be a multiple of 8");
  end

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    logic [INT_ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [SEG_BE_WIDTH-1:0]   wr_be, fwd_mask;
    logic [SEG_DATA_WIDTH-1:0] wr_data, rd_word;
    logic                      wr_acc, rd_acc, rd_ready, resp_valid, push, pop, rd_err;

    logic [SEG_DATA_WIDTH-1:0] mem [WORDS];

    logic [PIPELINE-1:0]       pv_q, pv_d, pe_q, pe_d;
    logic [SEG_DATA_WIDTH-1:0] pd_q [PIPELINE];
    logic [SEG_DATA_WIDTH-1:0] pd_d [PIPELINE];

    logic [SEG_DATA_WIDTH-1:0] fifo_data [OUT_FIFO_DEPTH];
    logic [OUT_FIFO_DEPTH-1:0] fifo_err;
    logic [PTR_W-1:0]          wp_q, wp_d, rp_q, rp_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cred_q, cred_d;
    logic                      wr_done_q, wr_done_d;

    assign wr_addr = wr_cmd_addr[n*SEG_ADDR_WIDTH +: INT_ADDR_WIDTH];
    assign rd_addr = rd_cmd_addr[n*SEG_ADDR_WIDTH +: INT_ADDR_WIDTH];
    assign wr_be   = wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH];
    assign wr_data = wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];

    // Ready comes only from registered credit, never from rd_resp_ready.
    assign rd_ready   = (cred_q < CNT_W'(OUT_FIFO_DEPTH)) & ~rst;
    assign resp_valid = (cnt_q != '0) & ~rst;
    assign push       = pv_q[PIPELINE-1];
    assign pop        = resp_valid & rd_resp_ready[n];

    always_comb begin
      wr_acc   = wr_cmd_valid[n] & ~rst;
      rd_acc   = rd_cmd_valid[n] & rd_ready;
      fwd_mask = (wr_acc && (wr_addr == rd_addr)) ? wr_be : '0;
      rd_word  = mem[rd_addr];
      for (int i = 0; i < SEG_BE_WIDTH; i++) begin
        if (fwd_mask[i]) rd_word[i*8 +: 8] = wr_data[i*8 +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (wr_acc) begin
        for (int i = 0; i < SEG_BE_WIDTH; i++) begin
          if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end

`ifdef DMA_PSDPRAM_PARITY_EN
    logic [SEG_BE_WIDTH-1:0] par_mem [WORDS];
    logic [SEG_BE_WIDTH-1:0] wr_par, rd_par;

    always_comb begin
      wr_par = '0;
      rd_par = par_mem[rd_addr];
      rd_err = 1'b0;
      for (int i = 0; i < SEG_BE_WIDTH; i++) begin
        wr_par[i] = (^wr_data[i*8 +: 8]) ^ wr_cmd_par_inv[n];
        if (fwd_mask[i]) rd_par[i] = wr_par[i];
        rd_err = rd_err | ((^rd_word[i*8 +: 8]) ^ rd_par[i]);
      end
    end

    always_ff @(posedge clk) begin
      if (wr_acc) begin
        for (int i = 0; i < SEG_BE_WIDTH; i++) begin
          if (wr_be[i]) par_mem[wr_addr][i] <= wr_par[i];
        end
      end
    end
`else
    assign rd_err = 1'b0;
`endif

    // Read pipeline never stalls: credit guarantees FIFO room for everything in flight.
    always_comb begin
      pv_d[0] = rd_acc;
      pd_d[0] = rd_word;
      pe_d[0] = rd_err;
      for (int s = 1; s < PIPELINE; s++) begin
        pv_d[s] = pv_q[s-1];
        pd_d[s] = pd_q[s-1];
        pe_d[s] = pe_q[s-1];
      end
      if (rst) pv_d = '0;
    end

    always_comb begin
      wp_d      = wp_q;
      rp_d      = rp_q;
      cnt_d     = cnt_q;
      cred_d    = cred_q;
      wr_done_d = wr_acc;
      if (push) wp_d = (wp_q == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (pop)  rp_d = (rp_q == PTR_W'(OUT_FIFO_DEPTH - 1)) ? '0 : rp_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
      if (rd_acc && !pop)      cred_d = cred_q + 1'b1;
      else if (!rd_acc && pop) cred_d = cred_q - 1'b1;
      if (rst) begin
        wp_d      = '0;
        rp_d      = '0;
        cnt_d     = '0;
        cred_d    = '0;
        wr_done_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      pv_q      <= pv_d;
      pd_q      <= pd_d;
      pe_q      <= pe_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      cred_q    <= cred_d;
      wr_done_q <= wr_done_d;
    end

    always_ff @(posedge clk) begin
      if (push) begin
        fifo_data[wp_q] <= pd_q[PIPELINE-1];
        fifo_err[wp_q]  <= pe_q[PIPELINE-1];
      end
    end

    assign wr_cmd_ready[n]  = ~rst;
    assign wr_done[n]       = wr_done_q & ~rst;
    assign rd_cmd_ready[n]  = rd_ready;
    assign rd_resp_valid[n] = resp_valid;
    assign rd_resp_err[n]   = resp_valid & fifo_err[rp_q];
    assign rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = fifo_data[rp_q];
  end

endmodule
